// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: requester, host and VRAM signals between the video core and the arbiter
interface vram_arbiter_if;
  logic        I_slot;
  logic        I_rnd_req;
  logic [13:0] I_rnd_addr;
  logic        O_rnd_grant;
  logic        O_rnd_valid;
  logic [7:0]  O_rnd_data;
  logic        I_host_req;
  logic        I_host_wren;
  logic [13:0] I_host_addr;
  logic [7:0]  I_host_data;
  logic        O_host_busy;
  logic        O_host_done;
  logic [7:0]  O_host_data;
  logic [13:0] O_mem_addr;
  logic        O_mem_wren;
  logic [7:0]  O_mem_data;
  logic [7:0]  I_mem_data;
  logic        O_slot_overrun;
  modport slave (
    input  I_slot, I_rnd_req, I_rnd_addr, I_host_req, I_host_wren, I_host_addr, I_host_data, I_mem_data,
    output O_rnd_grant, O_rnd_valid, O_rnd_data, O_host_busy, O_host_done, O_host_data,
           O_mem_addr, O_mem_wren, O_mem_data, O_slot_overrun
  );
  modport master (
    output I_slot, I_rnd_req, I_rnd_addr, I_host_req, I_host_wren, I_host_addr, I_host_data, I_mem_data,
    input  O_rnd_grant, O_rnd_valid, O_rnd_data, O_host_busy, O_host_done, O_host_data,
           O_mem_addr, O_mem_wren, O_mem_data, O_slot_overrun
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: slot-based VRAM port sharing, render priority with a host starvation guard
module vram_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input logic I_clock,
  input logic I_reset,
  vram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  state_t      state_q, state_d;
  logic        pend_q, pend_d, hwren_q, hwren_d, host_q, host_d;
  logic [13:0] haddr_q, haddr_d, mem_addr_q, mem_addr_d;
  logic [7:0]  hdata_q, hdata_d, mem_data_q, mem_data_d, rnd_data_q, rnd_data_d, host_data_q, host_data_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rnd_grant_q, rnd_grant_d, rnd_valid_q, rnd_valid_d, host_done_q, host_done_d;
  logic        mem_wren_q, mem_wren_d, overrun_q, overrun_d;
  logic        go, host_win, rnd_win, cap, accept;
  always_comb begin
    go          = state_q == IDLE && bus.I_slot;
    host_win    = go && pend_q && (cnt_q == LIM || !bus.I_rnd_req);
    rnd_win     = go && !host_win && bus.I_rnd_req;
    cap         = state_q == CAPTURE;
    accept      = bus.I_host_req && !pend_q;
    state_d     = (host_win || rnd_win) ? ACCESS : state_q == ACCESS ? CAPTURE : cap ? IDLE : state_q;
    host_d      = (host_win || rnd_win) ? host_win : host_q;
    host_done_d = cap && host_q;
    rnd_valid_d = cap && !host_q;
    rnd_data_d  = rnd_valid_d ? bus.I_mem_data : rnd_data_q;
    host_data_d = (host_done_d && !hwren_q) ? bus.I_mem_data : host_data_q;
    pend_d      = accept ? 1'b1 : host_done_d ? 1'b0 : pend_q;
    haddr_d     = accept ? bus.I_host_addr : haddr_q;
    hdata_d     = accept ? bus.I_host_data : hdata_q;
    hwren_d     = accept ? bus.I_host_wren : hwren_q;
    rnd_grant_d = rnd_win;
    mem_addr_d  = host_win ? haddr_q : rnd_win ? bus.I_rnd_addr : mem_addr_q;
    mem_wren_d  = host_win && hwren_q;
    mem_data_d  = mem_wren_d ? hdata_q : mem_data_q;
    overrun_d   = bus.I_slot && state_q != IDLE;
    // only slots lost to render while the host waits count toward starvation
    cnt_d       = (!pend_q || host_win) ? 4'd0 : (rnd_win && cnt_q != 4'hF) ? cnt_q + 4'd1 : cnt_q;
  end
  always_ff @(posedge I_clock or negedge I_reset)
    if (!I_reset) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      hwren_q     <= 1'b0;
      host_q      <= 1'b0;
      haddr_q     <= '0;
      hdata_q     <= '0;
      cnt_q       <= '0;
      rnd_grant_q <= 1'b0;
      rnd_valid_q <= 1'b0;
      rnd_data_q  <= '0;
      host_done_q <= 1'b0;
      host_data_q <= '0;
      mem_addr_q  <= '0;
      mem_wren_q  <= 1'b0;
      mem_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      hwren_q     <= hwren_d;
      host_q      <= host_d;
      haddr_q     <= haddr_d;
      hdata_q     <= hdata_d;
      cnt_q       <= cnt_d;
      rnd_grant_q <= rnd_grant_d;
      rnd_valid_q <= rnd_valid_d;
      rnd_data_q  <= rnd_data_d;
      host_done_q <= host_done_d;
      host_data_q <= host_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wren_q  <= mem_wren_d;
      mem_data_q  <= mem_data_d;
      overrun_q   <= overrun_d;
    end
  assign bus.O_rnd_grant    = rnd_grant_q;
  assign bus.O_rnd_valid    = rnd_valid_q;
  assign bus.O_rnd_data     = rnd_data_q;
  assign bus.O_host_busy    = pend_q;
  assign bus.O_host_done    = host_done_q;
  assign bus.O_host_data    = host_data_q;
  assign bus.O_mem_addr     = mem_addr_q;
  assign bus.O_mem_wren     = mem_wren_q;
  assign bus.O_mem_data     = mem_data_q;
  assign bus.O_slot_overrun = overrun_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of slot arbitration, starvation guard, overrun and reset abort
module tb_vram_arbiter;
  logic I_clock = 1'b0;
  logic I_reset = 1'b0;
  int compared = 0;
  int mismatched = 0;
  logic [7:0] mem [0:16383];
  vram_arbiter_if bus();
  vram_arbiter #(.STARVE_LIMIT(8)) dut (.I_clock(I_clock), .I_reset(I_reset), .bus(bus));
  always #5 I_clock = ~I_clock;
  // synchronous VRAM with one-cycle read latency
  always @(posedge I_clock) begin
    if (bus.O_mem_wren) mem[bus.O_mem_addr] <= bus.O_mem_data;
    bus.I_mem_data <= mem[bus.O_mem_addr];
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge I_clock);
    #1;
  endtask
  task automatic host_req(input logic wren, input logic [13:0] addr, input logic [7:0] data);
    bus.I_host_req = 1'b1;
    bus.I_host_wren = wren;
    bus.I_host_addr = addr;
    bus.I_host_data = data;
    step();
    bus.I_host_req = 1'b0;
  endtask
  task automatic slot();
    bus.I_slot = 1'b1;
    step();
    bus.I_slot = 1'b0;
  endtask
  function automatic logic [63:0] all_outs();
    return {20'd0, bus.O_rnd_grant, bus.O_rnd_valid, bus.O_rnd_data, bus.O_host_done, bus.O_host_busy,
            bus.O_host_data, bus.O_mem_addr, bus.O_mem_wren, bus.O_mem_data, bus.O_slot_overrun};
  endfunction
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h2000] = 8'h5A;
    mem[14'h2001] = 8'hA5;
    bus.I_mem_data = 8'h00;
    bus.I_slot = 1'b0;
    bus.I_rnd_req = 1'b0;
    bus.I_rnd_addr = '0;
    bus.I_host_req = 1'b0;
    bus.I_host_wren = 1'b0;
    bus.I_host_addr = '0;
    bus.I_host_data = '0;
    step();
    step();
    chk("reset_outs", all_outs(), 64'd0);
    I_reset = 1'b1;
    step();
    // render-only fetch
    bus.I_rnd_req = 1'b1;
    bus.I_rnd_addr = 14'h2000;
    slot();
    chk("rnd_grant", bus.O_rnd_grant, 1);
    chk("rnd_addr", bus.O_mem_addr, 14'h2000);
    chk("rnd_wren", bus.O_mem_wren, 0);
    step();
    chk("rnd_grant_pulse", bus.O_rnd_grant, 0);
    step();
    chk("rnd_valid", bus.O_rnd_valid, 1);
    chk("rnd_data", bus.O_rnd_data, 8'h5A);
    bus.I_rnd_addr = 14'h2001;
    slot();
    chk("rnd2_addr", bus.O_mem_addr, 14'h2001);
    step();
    step();
    chk("rnd2_data", {bus.O_rnd_valid, bus.O_rnd_data}, {1'b1, 8'hA5});
    bus.I_rnd_req = 1'b0;
    step();
    chk("rnd_valid_pulse", bus.O_rnd_valid, 0);
    // host write, no render
    host_req(1'b1, 14'h3F00, 8'h21);
    chk("hw_busy", bus.O_host_busy, 1);
    slot();
    chk("hw_access", {bus.O_mem_wren, bus.O_mem_addr, bus.O_mem_data, bus.O_rnd_grant}, {1'b1, 14'h3F00, 8'h21, 1'b0});
    step();
    chk("hw_wren_off", {bus.O_mem_wren, bus.O_mem_addr, bus.O_mem_data}, {1'b0, 14'h3F00, 8'h21});
    step();
    chk("hw_done", {bus.O_host_done, bus.O_host_busy, bus.O_host_data}, {1'b1, 1'b0, 8'h00});
    chk("hw_mem", mem[14'h3F00], 8'h21);
    step();
    chk("hw_done_pulse", bus.O_host_done, 0);
    // host read starved by render: 8 render wins, then host
    host_req(1'b0, 14'h3F00, 8'h00);
    bus.I_rnd_req = 1'b1;
    bus.I_rnd_addr = 14'h2000;
    for (int k = 0; k < 9; k++) begin
      slot();
      chk($sformatf("starve_grant%0d", k), bus.O_rnd_grant, (k < 8));
      chk($sformatf("starve_addr%0d", k), bus.O_mem_addr, (k < 8) ? 14'h2000 : 14'h3F00);
      step();
      step();
      chk($sformatf("starve_done%0d", k), {bus.O_rnd_valid, bus.O_host_done}, (k < 8) ? 2'b10 : 2'b01);
      if (k == 7) chk("starve_cnt8", dut.cnt_q, 8);
      step();
    end
    chk("starve_hdata", bus.O_host_data, 8'h21);
    chk("starve_cnt0", dut.cnt_q, 0);
    bus.I_rnd_req = 1'b0;
    // second request while busy is dropped, request in done cycle is accepted
    host_req(1'b0, 14'h2000, 8'h00);
    host_req(1'b1, 14'h0000, 8'hEE);
    slot();
    chk("drop_addr", {bus.O_mem_addr, bus.O_mem_wren}, {14'h2000, 1'b0});
    step();
    step();
    chk("drop_done", {bus.O_host_done, bus.O_host_busy, bus.O_host_data}, {1'b1, 1'b0, 8'h5A});
    host_req(1'b0, 14'h2001, 8'h00);
    chk("done_cycle_accept", {bus.O_host_busy, bus.O_host_done}, 2'b10);
    chk("drop_nowrite", mem[14'h0000], 8'h00);
    slot();
    step();
    step();
    chk("accept_done", {bus.O_host_done, bus.O_host_data}, {1'b1, 8'hA5});
    step();
    // slots two cycles apart
    bus.I_rnd_req = 1'b1;
    bus.I_rnd_addr = 14'h2000;
    slot();
    chk("ovr_grant", bus.O_rnd_grant, 1);
    step();
    slot();
    chk("ovr_pulse", {bus.O_slot_overrun, bus.O_rnd_valid, bus.O_rnd_grant}, 3'b110);
    bus.I_rnd_req = 1'b0;
    step();
    chk("ovr_no_access", {bus.O_slot_overrun, bus.O_rnd_grant, bus.O_rnd_valid}, 3'b000);
    step();
    step();
    chk("ovr_no_valid", bus.O_rnd_valid, 0);
    // reset during ACCESS of a host write
    host_req(1'b1, 14'h1000, 8'h99);
    slot();
    chk("rst_access", bus.O_mem_wren, 1);
    I_reset = 1'b0;
    #1;
    chk("rst_outs", all_outs(), 64'd0);
    step();
    I_reset = 1'b1;
    step();
    chk("rst_nowrite", mem[14'h1000], 8'h00);
    chk("rst_empty", bus.O_host_busy, 0);
    slot();
    chk("rst_idle", {bus.O_mem_wren, bus.O_rnd_grant}, 2'b00);
    step();
    step();
    chk("rst_nodone", {bus.O_host_done, bus.O_rnd_valid}, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
